// File: rtl/mat_pkg.sv
// Shared constants, FSM state type and packing helper for the
// systolic-array operand loader.
package mat_pkg;

    localparam int DW         = 4;
    localparam int N          = 3;
    localparam int NELEM      = N * N;
    localparam int RUN_CYCLES = 8;
    localparam int IW         = $clog2(NELEM);
    localparam int CW         = $clog2(RUN_CYCLES);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        CLR,
        RUN,
        DONE
    } state_t;

    function automatic int elem_lsb(input int k);
        return DW * k;
    endfunction

endpackage

// File: rtl/mat_pack_reg.sv
// Packed operand register bank: NELEM slots of DW bits, one slot
// written per enabled cycle at position idx.
module mat_pack_reg
    import mat_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IW-1:0]         idx,
    input  logic [DW-1:0]         din,
    output logic [NELEM*DW-1:0]   q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (we) begin
            for (int k = 0; k < NELEM; k++) begin
                if (idx == IW'(k)) begin
                    q[elem_lsb(k) +: DW] <= din;
                end
            end
        end
    end

endmodule

// File: rtl/mat_operand_loader.sv
// Streams A then B into packed operand buses and sequences the array.
// Optional LOADER_BREUSE_EN adds keep_b to reuse the previous B.
module mat_operand_loader
    import mat_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
`ifdef LOADER_BREUSE_EN
    input  logic                  keep_b,
`endif
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_data,
    output logic [NELEM*DW-1:0]   arr_in1,
    output logic [NELEM*DW-1:0]   arr_in2,
    output logic                  arr_rst,
    output logic                  arr_en,
    output logic                  done,
    output logic                  busy
);

    state_t        state, nstate;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          xfer, last, skip_b;
    logic          nxt_ready, nxt_arst, nxt_en, nxt_done, nxt_busy;

    // s_ready is only high in a load state, so it alone qualifies a transfer
    assign xfer = s_valid & s_ready;
    assign last = (idx == IW'(NELEM - 1));

`ifdef LOADER_BREUSE_EN
    assign skip_b = keep_b;
`else
    assign skip_b = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD_A;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            LOAD_A: if (xfer && last) nstate = skip_b ? CLR : LOAD_B;
            LOAD_B: if (xfer && last) nstate = CLR;
            CLR:    nstate = RUN;
            RUN:    if (cnt == '0) nstate = DONE;
            DONE:   nstate = LOAD_A;
            default: nstate = LOAD_A;
        endcase
    end

    always_comb begin
        nxt_ready = 1'b0;
        nxt_arst  = 1'b0;
        nxt_en    = 1'b0;
        nxt_done  = 1'b0;
        nxt_busy  = 1'b0;
        unique case (nstate)
            LOAD_A, LOAD_B: nxt_ready = 1'b1;
            CLR:  begin nxt_arst = 1'b1; nxt_busy = 1'b1; end
            RUN:  begin nxt_en   = 1'b1; nxt_busy = 1'b1; end
            DONE: begin nxt_done = 1'b1; nxt_busy = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ready <= 1'b0;
            arr_rst <= 1'b0;
            arr_en  <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            s_ready <= nxt_ready;
            arr_rst <= nxt_arst;
            arr_en  <= nxt_en;
            done    <= nxt_done;
            busy    <= nxt_busy;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
            cnt <= '0;
        end else begin
            if (xfer) idx <= last ? '0 : idx + 1'b1;
            if (state == CLR) begin
                cnt <= CW'(RUN_CYCLES - 1);
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    mat_pack_reg u_a (
        .clk (clk),
        .rst (rst),
        .we  (xfer && state == LOAD_A),
        .idx (idx),
        .din (s_data),
        .q   (arr_in1)
    );

    mat_pack_reg u_b (
        .clk (clk),
        .rst (rst),
        .we  (xfer && state == LOAD_B),
        .idx (idx),
        .din (s_data),
        .q   (arr_in2)
    );

endmodule
